// File: rtl/conway_grid_engine.sv
// Game of Life core: ROWS x COLS register grid with row load, single-step, and
// free-run at one generation per PERIOD clocks. Also tracks generations, population and stable/extinct.
module conway_grid_engine #(
  parameter int ROWS           = 8,
  parameter int COLS           = 8,
  parameter int WRAP           = 0,
  parameter int PERIOD         = 4,
  parameter int HALT_ON_STABLE = 1,
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int POP_W = $clog2(ROWS * COLS + 1)
) (
  input  logic                   sys_clk,
  input  logic                   Reset,
  input  logic                   load_en,
  input  logic [RW-1:0]          load_row,
  input  logic [COLS-1:0]        load_data,
  input  logic                   clear,
  input  logic                   run_toggle,
  input  logic                   step,
  output logic [ROWS*COLS-1:0]   grid,
  output logic [15:0]            gen_count,
  output logic [POP_W-1:0]       population,
  output logic                   running,
  output logic                   halted,
  output logic                   stable,
  output logic                   extinct
);

  localparam int N      = ROWS * COLS;
  localparam int TICK_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALTED} state_t;

  state_t              state_q, state_d;
  logic [N-1:0]        grid_q, grid_d, next_gen;
  logic [15:0]         gen_q, gen_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic                stable_q, stable_d;
  logic                extinct_q, extinct_d;
  logic                running_q, halted_q;
  logic                row_hit, load_ok, tick_hit, do_upd;

  // Next generation, fully parallel: one 8-neighbour counter per cell.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      localparam int RU = (r + ROWS - 1) % ROWS;
      localparam int RD = (r + 1) % ROWS;
      localparam int CL = (c + COLS - 1) % COLS;
      localparam int CR = (c + 1) % COLS;
      localparam bit HU = (WRAP != 0) || (r > 0);
      localparam bit HD = (WRAP != 0) || (r < ROWS - 1);
      localparam bit HL = (WRAP != 0) || (c > 0);
      localparam bit HR = (WRAP != 0) || (c < COLS - 1);

      logic [7:0] nb;
      logic [3:0] n;

      assign nb[0] = (HU && HL) ? grid_q[RU*COLS + CL] : 1'b0;
      assign nb[1] = HU         ? grid_q[RU*COLS + c ] : 1'b0;
      assign nb[2] = (HU && HR) ? grid_q[RU*COLS + CR] : 1'b0;
      assign nb[3] = HL         ? grid_q[r*COLS  + CL] : 1'b0;
      assign nb[4] = HR         ? grid_q[r*COLS  + CR] : 1'b0;
      assign nb[5] = (HD && HL) ? grid_q[RD*COLS + CL] : 1'b0;
      assign nb[6] = HD         ? grid_q[RD*COLS + c ] : 1'b0;
      assign nb[7] = (HD && HR) ? grid_q[RD*COLS + CR] : 1'b0;

      assign n = 4'($countones(nb));
      assign next_gen[r*COLS + c] = (n == 4'd3) | (grid_q[r*COLS + c] & (n == 4'd2));
    end
  end

  always_comb begin
    row_hit = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      if (load_row == RW'(r)) row_hit = 1'b1;
    end
  end

  assign load_ok  = load_en && (state_q != S_RUN) && row_hit;
  assign tick_hit = (state_q == S_RUN) && (tick_q == TICK_W'(PERIOD - 1));

  always_comb begin
    state_d   = state_q;
    grid_d    = grid_q;
    gen_d     = gen_q;
    stable_d  = stable_q;
    extinct_d = extinct_q;
    tick_d    = '0;
    do_upd    = 1'b0;

    if (clear) begin
      state_d   = S_IDLE;
      grid_d    = '0;
      gen_d     = '0;
      stable_d  = 1'b0;
      extinct_d = 1'b0;
    end else if (load_ok) begin
      for (int r = 0; r < ROWS; r++) begin
        if (load_row == RW'(r)) grid_d[r*COLS +: COLS] = load_data;
      end
      gen_d     = '0;
      stable_d  = 1'b0;
      extinct_d = 1'b0;
    end else if (run_toggle) begin
      state_d = (state_q == S_RUN) ? S_IDLE : S_RUN;
    end else if (state_q == S_RUN) begin
      if (tick_hit) begin
        do_upd = 1'b1;
        if ((HALT_ON_STABLE != 0) && ((next_gen == grid_q) || (next_gen == '0)))
          state_d = S_HALTED;
      end else begin
        tick_d = tick_q + 1'b1;
      end
    end else if (step) begin
      do_upd = 1'b1;
    end

    if (do_upd) begin
      grid_d    = next_gen;
      gen_d     = gen_q + 16'd1;
      stable_d  = (next_gen == grid_q);
      extinct_d = (next_gen == '0);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      grid_q    <= '0;
      gen_q     <= '0;
      tick_q    <= '0;
      stable_q  <= 1'b0;
      extinct_q <= 1'b0;
      running_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      grid_q    <= grid_d;
      gen_q     <= gen_d;
      tick_q    <= tick_d;
      stable_q  <= stable_d;
      extinct_q <= extinct_d;
      running_q <= (state_d == S_RUN);
      halted_q  <= (state_d == S_HALTED);
    end
  end

  assign grid       = grid_q;
  assign gen_count  = gen_q;
  assign population = POP_W'($countones(grid_q));
  assign running    = running_q;
  assign halted     = halted_q;
  assign stable     = stable_q;
  assign extinct    = extinct_q;

endmodule

// File: tb/tb_conway_grid_engine.sv
// Bench for conway_grid_engine: two instances (5x6 dead-border, 8x8 toroidal)
// driven in lockstep and compared each cycle against a cell-by-cell Life model.
module tb_conway_grid_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ld_en = 1'b0;
  logic [2:0]  ld_row = '0;
  logic [7:0]  ld_data = '0;
  logic        clr = 1'b0;
  logic        tog = 1'b0;
  logic        stp = 1'b0;

  logic [29:0] g0;
  logic [63:0] g1;
  logic [15:0] gen0, gen1;
  logic [4:0]  pop0;
  logic [6:0]  pop1;
  logic        run0, run1, hlt0, hlt1, stb0, stb1, ext0, ext1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  conway_grid_engine #(.ROWS(5), .COLS(6), .WRAP(0), .PERIOD(4), .HALT_ON_STABLE(1)) dut0 (
    .sys_clk(clk), .Reset(rst), .load_en(ld_en), .load_row(ld_row), .load_data(ld_data[5:0]),
    .clear(clr), .run_toggle(tog), .step(stp), .grid(g0), .gen_count(gen0),
    .population(pop0), .running(run0), .halted(hlt0), .stable(stb0), .extinct(ext0));

  conway_grid_engine #(.ROWS(8), .COLS(8), .WRAP(1), .PERIOD(1), .HALT_ON_STABLE(0)) dut1 (
    .sys_clk(clk), .Reset(rst), .load_en(ld_en), .load_row(ld_row), .load_data(ld_data),
    .clear(clr), .run_toggle(tog), .step(stp), .grid(g1), .gen_count(gen1),
    .population(pop1), .running(run1), .halted(hlt1), .stable(stb1), .extinct(ext1));

  // Reference model: state 0 = idle, 1 = run, 2 = halted.
  int          MR[2] = '{5, 8};
  int          MC[2] = '{6, 8};
  int          MW[2] = '{0, 1};
  int          MP[2] = '{4, 1};
  int          MH[2] = '{1, 0};
  logic [63:0] mg[2]   = '{64'd0, 64'd0};
  logic [15:0] mgen[2] = '{16'd0, 16'd0};
  int          mst[2]  = '{0, 0};
  int          mtk[2]  = '{0, 0};
  bit          mstb[2] = '{1'b0, 1'b0};
  bit          mext[2] = '{1'b0, 1'b0};

  function automatic logic [63:0] life(logic [63:0] g, int R, int C, int wr);
    logic [63:0] nx = '0;
    for (int r = 0; r < R; r++) begin
      for (int c = 0; c < C; c++) begin
        int n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            int rr = r + dr;
            int cc = c + dc;
            if (dr == 0 && dc == 0) continue;
            if (wr != 0) begin
              rr = (rr + R) % R;
              cc = (cc + C) % C;
            end else if (rr < 0 || rr >= R || cc < 0 || cc >= C) begin
              continue;
            end
            n += int'(g[rr*C + cc]);
          end
        end
        nx[r*C + c] = (n == 3) || (g[r*C + c] && n == 2);
      end
    end
    return nx;
  endfunction

  task automatic model_edge(int d);
    logic [63:0] nx;
    bit upd = 1'b0;
    if (rst || clr) begin
      mg[d] = '0; mgen[d] = '0; mst[d] = 0; mtk[d] = 0; mstb[d] = 1'b0; mext[d] = 1'b0;
      return;
    end
    if (ld_en && mst[d] != 1 && int'(ld_row) < MR[d]) begin
      for (int c = 0; c < MC[d]; c++) mg[d][int'(ld_row)*MC[d] + c] = ld_data[c];
      mgen[d] = '0; mstb[d] = 1'b0; mext[d] = 1'b0;
      return;
    end
    if (tog) begin
      mst[d] = (mst[d] == 1) ? 0 : 1;
      mtk[d] = 0;
      return;
    end
    if (mst[d] == 1) begin
      if (mtk[d] == MP[d] - 1) begin
        mtk[d] = 0;
        upd = 1'b1;
      end else begin
        mtk[d]++;
      end
    end else if (stp) begin
      upd = 1'b1;
    end
    if (upd) begin
      nx = life(mg[d], MR[d], MC[d], MW[d]);
      mstb[d] = (nx == mg[d]);
      mext[d] = (nx == '0);
      mg[d] = nx;
      mgen[d] = mgen[d] + 16'd1;
      if (mst[d] == 1 && MH[d] != 0 && (mstb[d] || mext[d])) mst[d] = 2;
    end
  endtask

  always @(posedge clk) begin
    model_edge(0);
    model_edge(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("d0.grid", 64'(g0), mg[0]);
    check("d0.gen", 64'(gen0), 64'(mgen[0]));
    check("d0.pop", 64'(pop0), 64'($countones(mg[0])));
    check("d0.running", 64'(run0), 64'(mst[0] == 1));
    check("d0.halted", 64'(hlt0), 64'(mst[0] == 2));
    check("d0.stable", 64'(stb0), 64'(mstb[0]));
    check("d0.extinct", 64'(ext0), 64'(mext[0]));
    check("d1.grid", g1, mg[1]);
    check("d1.gen", 64'(gen1), 64'(mgen[1]));
    check("d1.pop", 64'(pop1), 64'($countones(mg[1])));
    check("d1.running", 64'(run1), 64'(mst[1] == 1));
    check("d1.halted", 64'(hlt1), 64'(mst[1] == 2));
    check("d1.stable", 64'(stb1), 64'(mstb[1]));
    check("d1.extinct", 64'(ext1), 64'(mext[1]));
  endtask

  task automatic run_cyc(input bit do_cmp);
    @(posedge clk);
    #1;
    if (do_cmp) compare_all();
  endtask

  task automatic do_load(input logic [2:0] row, input logic [7:0] data);
    ld_en = 1'b1; ld_row = row; ld_data = data;
    run_cyc(1'b1);
    ld_en = 1'b0;
  endtask

  task automatic do_clear();
    clr = 1'b1; run_cyc(1'b1); clr = 1'b0;
  endtask

  task automatic do_step();
    stp = 1'b1; run_cyc(1'b1); stp = 1'b0;
  endtask

  task automatic do_toggle();
    tog = 1'b1; run_cyc(1'b1); tog = 1'b0;
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    run_cyc(1'b0);
    run_cyc(1'b1);
    check("rst.grid1", g1, 64'd0);
    check("rst.gen0", 64'(gen0), 64'd0);
    rst = 1'b0;

    // Blinker in the 5x6 dead-border grid
    do_load(3'd2, 8'b0000_1110);
    do_step();
    check("blink.grid", 64'(g0), (64'd1 << 8) | (64'd1 << 14) | (64'd1 << 20));
    check("blink.gen", 64'(gen0), 64'd1);
    check("blink.pop", 64'(pop0), 64'd3);
    check("blink.stable", 64'(stb0), 64'd0);
    do_step();
    check("blink.back", 64'(g0), (64'd1 << 13) | (64'd1 << 14) | (64'd1 << 15));
    check("blink.gen2", 64'(gen0), 64'd2);

    // Corner trio: forms a wrapped block on the torus, dies on the dead border
    do_clear();
    do_load(3'd0, 8'h81);
    do_load(3'd7, 8'h01);
    do_step();
    check("corner.grid1", g1, 64'h8100_0000_0000_0081);
    check("corner.pop1", 64'(pop1), 64'd4);
    check("corner.grid0", 64'(g0), 64'd0);
    check("corner.ext0", 64'(ext0), 64'd1);
    do_step();
    check("corner.stable1", 64'(stb1), 64'd1);

    // Glider returns home after 32 generations on the 8x8 torus
    do_clear();
    do_load(3'd0, 8'b010);
    do_load(3'd1, 8'b100);
    do_load(3'd2, 8'b111);
    do_toggle();
    for (int i = 0; i < 32; i++) run_cyc(1'b1);
    check("glider.grid", g1, 64'h0000_0000_0007_0402);
    check("glider.gen", 64'(gen1), 64'd32);
    check("glider.running", 64'(run1), 64'd1);
    do_load(3'd0, 8'hFF);
    check("ld_in_run.gen", 64'(gen1), 64'd33);
    do_step();
    check("step_in_run.gen", 64'(gen1), 64'd34);
    do_toggle();
    tog = 1'b1; stp = 1'b1; run_cyc(1'b1); tog = 1'b0; stp = 1'b0;
    check("tog_step.running", 64'(run1), 64'd1);
    check("tog_step.gen", 64'(gen1), 64'd34);
    do_toggle();

    // Auto-halt on a still life with PERIOD=4
    do_clear();
    do_load(3'd1, 8'b0110);
    do_load(3'd2, 8'b0110);
    do_toggle();
    for (int i = 0; i < 3; i++) run_cyc(1'b1);
    check("halt.pre_gen", 64'(gen0), 64'd0);
    run_cyc(1'b1);
    check("halt.gen", 64'(gen0), 64'd1);
    check("halt.stable", 64'(stb0), 64'd1);
    check("halt.halted", 64'(hlt0), 64'd1);
    check("halt.running", 64'(run0), 64'd0);
    for (int i = 0; i < 20; i++) run_cyc(1'b1);
    check("halt.hold_gen", 64'(gen0), 64'd1);

    // Reset in the middle of a run
    do_clear();
    do_load(3'd2, 8'b0000_1110);
    do_toggle();
    for (int i = 0; i < 7; i++) run_cyc(1'b1);
    check("midrst.gen_before", 64'(gen1), 64'd7);
    rst = 1'b1; run_cyc(1'b1); rst = 1'b0;
    check("midrst.grid", g1, 64'd0);
    check("midrst.gen", 64'(gen1), 64'd0);
    check("midrst.running", 64'(run1), 64'd0);
    check("midrst.pop", 64'(pop1), 64'd0);

    // gen_count wrap FFFF -> 0000
    do_load(3'd2, 8'b0000_1110);
    do_toggle();
    for (int i = 0; i < 65535; i++) run_cyc(1'b0);
    check("wrap.ffff", 64'(gen1), 64'hFFFF);
    do_toggle();
    check("wrap.stopped", 64'(gen1), 64'hFFFF);
    do_step();
    check("wrap.zero", 64'(gen1), 64'h0000);

    // Randomized traffic
    do_clear();
    for (int i = 0; i < 3000; i++) begin
      rst     = ($urandom_range(0, 299) == 0);
      clr     = ($urandom_range(0, 99) == 0);
      ld_en   = ($urandom_range(0, 5) == 0);
      ld_row  = 3'($urandom_range(0, 7));
      ld_data = 8'($urandom);
      tog     = ($urandom_range(0, 15) == 0);
      stp     = ($urandom_range(0, 3) == 0);
      run_cyc(1'b1);
    end
    rst = 1'b0; clr = 1'b0; ld_en = 1'b0; tog = 1'b0; stp = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/conway_grid_engine.md
# conway_grid_engine

Parametrised Game of Life core that holds a ROWS x COLS cell grid in registers and advances it one generation per update. Dead-border or toroidal edges are selected at elaboration. It sits between the board top (buttons, switches, SSD/LED drivers) and any display scanner. It adds row loading, single-step, free-run at a programmable rate, a generation counter, a population count and stable/extinct detection with optional auto-halt.

## Interface
- ROWS, 8, grid rows (>=3)
- COLS, 8, grid columns (>=3); also row load width
- WRAP, 0, 0 = cells outside grid are dead; 1 = toroidal wrap on both axes
- PERIOD, 4, sys_clk cycles per generation in RUN (>=1)
- HALT_ON_STABLE, 1, 1 = RUN moves to HALTED when a generation is stable or extinct
- sys_clk  in  1  sole clock; all state changes on rising edge
- Reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- load_en  in  1  write load_data into row load_row (IDLE/HALTED only)
- load_row  in  $clog2(ROWS)  target row; values >= ROWS ignored
- load_data  in  COLS  bit c = cell (load_row, c)
- clear  in  1  zero grid, gen_count, flags; any state -> IDLE
- run_toggle  in  1  single-cycle pulse (debounced/pulsed upstream)
- step  in  1  single-cycle pulse: one generation in IDLE/HALTED
- grid  out  ROWS*COLS  bit r*COLS+c = cell (r,c), 1 = alive
- gen_count  out  16  generations since reset/clear/load, wraps FFFF->0000
- population  out  $clog2(ROWS*COLS+1)  live cells in grid (combinational from grid)
- running  out  1  state == RUN
- halted  out  1  state == HALTED
- stable  out  1  last update produced next == current
- extinct  out  1  last update produced all-dead grid

## Operation
- Rule per cell: n = live neighbours among 8; next = (n==3) | (alive & n==2).
- Neighbours off-grid: WRAP=0 -> 0; WRAP=1 -> index mod ROWS / mod COLS.
- States: IDLE, RUN, HALTED.
  - IDLE: run_toggle -> RUN; step -> one update, stay IDLE.
  - RUN: run_toggle -> IDLE. An update occurs on tick. With HALT_ON_STABLE=1 and the update's next==current or next==0, the state moves to HALTED on the same edge.
  - HALTED: run_toggle -> RUN; step -> one update, stay HALTED.
- Update edge: grid<=next, gen_count<=gen_count+1, stable<=(next==grid), extinct<=(next==0).
- Priority per edge: Reset > clear > load_en > run_toggle > step/tick.
  - load_en in RUN is ignored.
  - load_en in IDLE/HALTED writes the row, zeroes gen_count, stable and extinct, and suppresses step that cycle.
- run_toggle and step in the same cycle: only run_toggle acts.
- step in RUN is ignored.
- Tick counter: 0..PERIOD-1, zeroed on every entry to RUN and outside RUN. Tick when counter==PERIOD-1 in RUN; the counter then returns to 0. PERIOD=1 gives an update every cycle.

## Timing
- Reset values: grid=0, gen_count=0, state=IDLE, stable=0, extinct=0, running=0, halted=0, population=0, tick counter=0.
- Reset mid-RUN: all of the above on the next edge; in-flight tick discarded.
- step accepted at edge k: new grid, gen_count, stable and extinct visible after edge k (1-cycle latency).
- run_toggle at edge k into RUN: updates at edges k+PERIOD, k+2*PERIOD, ...
- load visible in grid after the load edge; population is valid the same cycle as grid.
- stable/extinct hold until the next update, load, clear or Reset.

## Test plan
- Blinker, ROWS=COLS=5, WRAP=0: load row2=5'b01110; step -> cells (1,2),(2,2),(3,2) alive, gen_count=1, population=3, stable=0. Step again -> original grid, gen_count=2.
- Corner trio, 8x8: load (0,0),(0,7),(7,0) alive.
  - WRAP=1: one step -> 4 cells incl. (7,7), population=4; next step stable=1.
  - WRAP=0: one step -> grid=0, extinct=1.
- Glider, 8x8, WRAP=1, PERIOD=1, HALT_ON_STABLE=0: run 32 cycles from run_toggle -> grid equals initial, gen_count=32, running=1.
- Auto-halt, PERIOD=4, HALT_ON_STABLE=1: load 2x2 block, run_toggle at edge k.
  - Edge k+4: gen_count=1, stable=1, halted=1, running=0.
  - No further gen_count change for 20 cycles.
- Priority/ignore:
  - load_en during RUN -> grid unchanged.
  - step in RUN -> no extra update.
  - run_toggle+step same cycle in IDLE -> RUN, gen_count unchanged.
- Reset mid-RUN at gen_count=7 -> next edge all outputs at reset values.
- gen_count wrap: force 16'hFFFF then step -> 16'h0000.
